// File: rtl/seg_scan_driver_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared constants for the seven-segment scan driver: the 16-entry font
// (segments {a,b,c,d,e,f,g} on bits 6..0, active-high), the blank pattern
// and the bit position of each segment inside a 7-bit segment word.
// No ports; imported by the font decoder and the scan driver top level.
// -----------------------------------------------------------------------------
package seg_pkg;

    // Bit position of each segment within a seg[6:0] word
    localparam int SEG_A_BIT = 6;
    localparam int SEG_B_BIT = 5;
    localparam int SEG_C_BIT = 4;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 2;
    localparam int SEG_F_BIT = 1;
    localparam int SEG_G_BIT = 0;

    // All segments off
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Glyphs for 0-9 and A, b, C, d, E, F
    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h1F;
    localparam logic [6:0] SEG_C = 7'h4E;
    localparam logic [6:0] SEG_D = 7'h3D;
    localparam logic [6:0] SEG_E = 7'h4F;
    localparam logic [6:0] SEG_F = 7'h47;

endpackage

// File: rtl/seg_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg_scan_driver_if
// Bundles the datapath-side controls and the display-side pins of the scan
// driver.
//   load       : one-cycle strobe, capture value into the shadow register
//   value      : 4*NUM_DIGITS bits, nibble i is digit i (digit 0 = LS)
//   mode       : 0 = BCD (codes 10-15 blank), 1 = hex
//   blank_en   : 1 = suppress leading zeros
//   seg        : segments {a..g} on bits 6..0, active-high
//   dig_sel    : one-hot digit enable, active-high
//   frame_done : one-cycle pulse at the end of each scan frame
// master = the datapath/testbench side, slave = the driver.
// -----------------------------------------------------------------------------
interface seg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic                      mode;
    logic                      blank_en;
    logic [6:0]                seg;
    logic [NUM_DIGITS-1:0]     dig_sel;
    logic                      frame_done;

    modport master (
        output load, value, mode, blank_en,
        input  seg, dig_sel, frame_done
    );

    modport slave (
        input  load, value, mode, blank_en,
        output seg, dig_sel, frame_done
    );
endinterface

// File: rtl/seg_scan_driver_font.sv
// -----------------------------------------------------------------------------
// seg_font
// Purely combinational nibble-to-glyph decoder.
//   nibble_i : 4-bit digit code
//   mode_i   : 0 = BCD (codes 10-15 show nothing), 1 = hex letters
//   seg_o    : segments {a..g} on bits 6..0, active-high
// -----------------------------------------------------------------------------
module seg_font
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       mode_i,
    output logic [6:0] seg_o
);

    // Straight table lookup; in BCD mode the letter codes are forced dark so
    // an out-of-range BCD digit is visibly empty rather than a stray letter.
    always_comb begin
        seg_o = SEG_BLANK;
        unique case (nibble_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = mode_i ? SEG_A : SEG_BLANK;
            4'hB: seg_o = mode_i ? SEG_B : SEG_BLANK;
            4'hC: seg_o = mode_i ? SEG_C : SEG_BLANK;
            4'hD: seg_o = mode_i ? SEG_D : SEG_BLANK;
            4'hE: seg_o = mode_i ? SEG_E : SEG_BLANK;
            4'hF: seg_o = mode_i ? SEG_F : SEG_BLANK;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexed multi-digit seven-segment driver. Each digit is held for
// SCAN_DIV cycles; a full pass over NUM_DIGITS digits is one frame. New values
// land in a shadow register and are only copied to the displayed register at
// a frame boundary, so a frame never shows a mix of old and new digits.
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset
//   bus : seg_scan_driver_if slave (load/value/mode/blank_en in,
//         seg/dig_sel/frame_done out, all outputs registered)
// -----------------------------------------------------------------------------
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_driver_if.slave  bus
);

    localparam int DIV_W = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;

    logic [DIV_W-1:0]      divCnt_q,    divCnt_d;
    logic [IDX_W-1:0]      idx_q,       idx_d;
    logic [VAL_W-1:0]      dispReg_q,   dispReg_d;
    logic [VAL_W-1:0]      shadow_q,    shadow_d;
    logic                  pending_q,   pending_d;
    logic [6:0]            seg_q,       seg_d;
    logic [NUM_DIGITS-1:0] digSel_q,    digSel_d;
    logic                  frameDone_q, frameDone_d;

    logic       tick;
    logic       lastDigit;
    logic       frameEnd;
    logic [3:0] curNibble;
    logic       curZeroAbove;
    logic       zeroRun;
    logic [6:0] fontSeg;

    assign tick      = (divCnt_q == DIV_W'(SCAN_DIV - 1));
    assign lastDigit = (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign frameEnd  = tick && lastDigit;

    // Pick out the nibble of the digit being scanned and, walking down from
    // the most significant digit, note whether it and every digit above it
    // are zero. That "zero from here up" flag is what leading-zero blanking
    // needs.
    always_comb begin
        curNibble    = 4'h0;
        curZeroAbove = 1'b0;
        zeroRun      = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zeroRun = zeroRun && (dispReg_q[4*i +: 4] == 4'h0);
            if (idx_q == IDX_W'(i)) begin
                curNibble    = dispReg_q[4*i +: 4];
                curZeroAbove = zeroRun;
            end
        end
    end

    seg_font u_font (
        .nibble_i (curNibble),
        .mode_i   (bus.mode),
        .seg_o    (fontSeg)
    );

    // Next-state for the divider, scan index, buffers and output registers.
    // The boundary transfer is evaluated before the load so that a load
    // landing on the boundary cycle still ends up in the shadow with pending
    // set, while the boundary moves the previous shadow contents.
    always_comb begin
        divCnt_d    = tick ? '0 : divCnt_q + DIV_W'(1);
        idx_d       = idx_q;
        dispReg_d   = dispReg_q;
        shadow_d    = shadow_q;
        pending_d   = pending_q;

        if (tick) begin
            idx_d = lastDigit ? '0 : idx_q + IDX_W'(1);
        end

        if (frameEnd && pending_q) begin
            dispReg_d = shadow_q;
            pending_d = 1'b0;
        end

        if (bus.load) begin
            shadow_d  = bus.value;
            pending_d = 1'b1;
        end

        // Digit 0 is never blanked so an all-zero value still shows "0"
        if (bus.blank_en && (idx_q != '0) && curZeroAbove) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = fontSeg;
        end
        digSel_d    = NUM_DIGITS'(1) << idx_q;
        frameDone_d = frameEnd;
    end

    // All state, including the display outputs, registered with a
    // synchronous reset that also drops any pending shadow value.
    always_ff @(posedge clk) begin
        if (rst) begin
            divCnt_q    <= '0;
            idx_q       <= '0;
            dispReg_q   <= '0;
            shadow_q    <= '0;
            pending_q   <= 1'b0;
            seg_q       <= SEG_BLANK;
            digSel_q    <= '0;
            frameDone_q <= 1'b0;
        end else begin
            divCnt_q    <= divCnt_d;
            idx_q       <= idx_d;
            dispReg_q   <= dispReg_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            seg_q       <= seg_d;
            digSel_q    <= digSel_d;
            frameDone_q <= frameDone_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dig_sel    = digSel_q;
    assign bus.frame_done = frameDone_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
// Self-checking bench for seg_scan_driver with NUM_DIGITS=4, SCAN_DIV=4.
// A reference model derives the expected display from the number of cycles
// since reset and the load history; outputs are compared every cycle, and a
// set of directed scenarios pin literal glyph values.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int FRAME = N * SD;

    localparam logic [6:0] FONT [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    logic clk = 1'b0;
    logic rst;

    int checks   = 0;
    int failures = 0;

    seg_scan_driver_if #(.NUM_DIGITS(N)) bus ();

    seg_scan_driver #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (SD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model state: cycles since reset release, what is on display, and the
    // buffered value waiting for the next frame.
    int          k;
    logic [15:0] mDisp;
    logic [15:0] mShadow;
    bit          mPending;
    logic [6:0]  expSeg;
    logic [3:0]  expDig;
    logic        expFd;
    bit          expValid = 0;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] modelSeg(input int idx, input logic [15:0] disp,
                                            input logic md, input logic bl);
        logic [15:0] above;
        logic [3:0]  nib;
        above = disp >> (4 * idx);
        nib   = above[3:0];
        if (bl && idx > 0 && above == 16'h0) return 7'h00;
        if (!md && nib > 4'd9) return 7'h00;
        return FONT[nib];
    endfunction

    // The model advances on every rising edge: the digit being scanned is
    // just (k / SD) mod N, and a frame ends on the last cycle of each
    // FRAME-cycle period. Expectations computed here appear on the outputs
    // one cycle later.
    always @(posedge clk) begin
        if (rst) begin
            k        = 0;
            mDisp    = 16'h0;
            mShadow  = 16'h0;
            mPending = 0;
            expSeg   = 7'h00;
            expDig   = 4'h0;
            expFd    = 1'b0;
        end else begin
            int idx;
            bit boundary;
            idx      = (k / SD) % N;
            boundary = (k % FRAME) == FRAME - 1;
            expSeg   = modelSeg(idx, mDisp, bus.mode, bus.blank_en);
            expDig   = 4'(1 << idx);
            expFd    = boundary;
            if (boundary && mPending) begin
                mDisp    = mShadow;
                mPending = 0;
            end
            if (bus.load) begin
                mShadow  = bus.value;
                mPending = 1;
            end
            k++;
        end
        expValid = 1;
    end

    // Per-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (expValid) begin
            checkOutput("modelSeg", 32'(bus.seg), 32'(expSeg));
            checkOutput("modelDig", 32'(bus.dig_sel), 32'(expDig));
            checkOutput("modelFd", 32'(bus.frame_done), 32'(expFd));
        end
    end

    // Drive one load strobe from a falling edge, dropping it a cycle later.
    task automatic applyStimulus(input logic [15:0] v);
        bus.load  = 1'b1;
        bus.value = v;
        @(negedge clk);
        bus.load  = 1'b0;
    endtask

    // Wait (bounded) for the next frame_done pulse.
    task automatic waitFrame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_done && n < 100);
        checkOutput("frameWait", 32'(bus.frame_done), 32'd1);
    endtask

    // Load a value safely inside a frame, a few cycles after a boundary.
    task automatic loadMidFrame(input logic [15:0] v);
        waitFrame();
        repeat (4) @(negedge clk);
        applyStimulus(v);
    endtask

    // Capture the frame following the next boundary and compare each digit.
    task automatic captureFrame(input string tag, input logic [6:0] e0,
                                input logic [6:0] e1, input logic [6:0] e2,
                                input logic [6:0] e3);
        logic [7:0] got [N];
        for (int i = 0; i < N; i++) got[i] = 8'hFF;
        waitFrame();
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (bus.dig_sel == 4'(1 << i)) got[i] = {1'b0, bus.seg};
            end
        end
        checkOutput({tag, "_d0"}, 32'(got[0]), 32'(e0));
        checkOutput({tag, "_d1"}, 32'(got[1]), 32'(e1));
        checkOutput({tag, "_d2"}, 32'(got[2]), 32'(e2));
        checkOutput({tag, "_d3"}, 32'(got[3]), 32'(e3));
    endtask

    initial begin
        int fdCount;
        logic [3:0] digSeq [4];
        digSeq[0] = 4'b0010; digSeq[1] = 4'b0100;
        digSeq[2] = 4'b1000; digSeq[3] = 4'b0001;

        rst          = 1'b1;
        bus.load     = 1'b0;
        bus.value    = 16'h0;
        bus.mode     = 1'b0;
        bus.blank_en = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("resetSeg", 32'(bus.seg), 32'h00);
        checkOutput("resetDig", 32'(bus.dig_sel), 32'h0);
        checkOutput("resetFd", 32'(bus.frame_done), 32'h0);

        // First digit one cycle after release, then dig_sel walks every SD
        rst = 1'b0;
        @(negedge clk);
        checkOutput("firstDig", 32'(bus.dig_sel), 32'b0001);
        checkOutput("firstSeg", 32'(bus.seg), 32'h7E);
        for (int j = 0; j < 4; j++) begin
            repeat (SD) @(negedge clk);
            checkOutput("walkDig", 32'(bus.dig_sel), 32'(digSeq[j]));
        end
        fdCount = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            if (bus.frame_done) fdCount++;
        end
        checkOutput("fdPerFrame", 32'(fdCount), 32'd2);

        // BCD value, buffered until the boundary
        waitFrame();
        repeat (4) @(negedge clk);
        applyStimulus(16'h1234);
        checkOutput("preBoundary", 32'(bus.seg), 32'h7E);
        captureFrame("v1234", 7'h33, 7'h79, 7'h6D, 7'h30);

        // Leading-zero blanking, then blanking turned off live
        bus.blank_en = 1'b1;
        loadMidFrame(16'h0070);
        captureFrame("blankOn", 7'h7E, 7'h70, 7'h00, 7'h00);
        bus.blank_en = 1'b0;
        captureFrame("blankOff", 7'h7E, 7'h70, 7'h7E, 7'h7E);

        // Hex letters, then BCD mode darkens them
        bus.mode = 1'b1;
        loadMidFrame(16'hABCD);
        captureFrame("hexABCD", 7'h3D, 7'h4E, 7'h1F, 7'h77);
        bus.mode = 1'b0;
        captureFrame("bcdABCD", 7'h00, 7'h00, 7'h00, 7'h00);

        // Load on the boundary cycle itself, then last-load-wins
        waitFrame();
        repeat (FRAME - 1) @(negedge clk);
        applyStimulus(16'h1111);
        checkOutput("loadOnBoundary", 32'(bus.frame_done), 32'd1);
        waitFrame();
        @(negedge clk);
        checkOutput("show1111", 32'(bus.seg), 32'h30);
        applyStimulus(16'h2222);
        applyStimulus(16'h3333);
        captureFrame("lastWins", 7'h79, 7'h79, 7'h79, 7'h79);

        // Reset discards a pending load
        loadMidFrame(16'h9999);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("midResetSeg", 32'(bus.seg), 32'h00);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("postResetDig", 32'(bus.dig_sel), 32'b0001);
        checkOutput("postResetSeg", 32'(bus.seg), 32'h7E);
        captureFrame("noPending", 7'h7E, 7'h7E, 7'h7E, 7'h7E);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            bus.load  = ($urandom_range(0, 7) == 0);
            bus.value = 16'($urandom);
            if ($urandom_range(0, 3) == 0) bus.value = bus.value & 16'h00FF;
            if ($urandom_range(0, 31) == 0) bus.mode = ~bus.mode;
            if ($urandom_range(0, 31) == 0) bus.blank_en = ~bus.blank_en;
            rst = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        bus.load = 1'b0;
        rst      = 1'b0;
        repeat (2 * FRAME) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

endmodule
